// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: data-memory access FSM, load extension and register writeback
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        reg_write,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, next_state;
  logic        accept, is_mem, legal;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [1:0]  off_q;
  logic [31:0] shifted, load_val;

  assign in_ready = (state == IDLE);
  assign dm_req   = (state == REQ);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_is_load || in_is_store;

  // Width code and alignment check; a load flag takes precedence over a store flag.
  always_comb begin
    legal = 1'b0;
    if (in_is_load) begin
      case (in_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~in_addr[0];
        3'b010:         legal = (in_addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end else begin
      case (in_funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~in_addr[0];
        3'b010:  legal = (in_addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    st_we    = 4'b0000;
    st_wdata = 32'h0;
    if (!in_is_load) begin
      case (in_funct3[1:0])
        2'b00: begin
          st_we    = 4'b0001 << in_addr[1:0];
          st_wdata = {4{in_store_data[7:0]}};
        end
        2'b01: begin
          st_we    = 4'b0011 << {in_addr[1], 1'b0};
          st_wdata = {2{in_store_data[15:0]}};
        end
        2'b10: begin
          st_we    = 4'b1111;
          st_wdata = in_store_data;
        end
        default: begin
          st_we    = 4'b0000;
          st_wdata = 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && is_mem && legal) next_state = REQ;
      REQ:     if (dm_gnt) next_state = is_load_q ? WAIT : IDLE;
      WAIT:    if (dm_rvalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    shifted = dm_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_we      <= 4'b0000;
      dm_addr    <= 32'h0;
      dm_wdata   <= 32'h0;
      is_load_q  <= 1'b0;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      off_q      <= 2'b00;
      reg_write  <= 1'b0;
      write_addr <= 5'd0;
      write_data <= 32'h0;
      err        <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (!is_mem) begin
            if (in_reg_write && in_rd != 5'd0) begin
              reg_write  <= 1'b1;
              write_addr <= in_rd;
              write_data <= in_addr;
            end
          end else if (!legal) begin
            err <= 1'b1;
          end else begin
            // Request fields are frozen here and held until the grant.
            dm_addr   <= {in_addr[31:2], 2'b00};
            dm_we     <= st_we;
            dm_wdata  <= st_wdata;
            is_load_q <= in_is_load;
            funct3_q  <= in_funct3;
            rd_q      <= in_rd;
            off_q     <= in_addr[1:0];
          end
        end
        WAIT: if (dm_rvalid && rd_q != 5'd0) begin
          reg_write  <= 1'b1;
          write_addr <= rd_q;
          write_data <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_reg_write, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_addr, in_store_data;
  logic        dm_req, dm_gnt, dm_rvalid;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        reg_write, err;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_addr(in_addr), .in_store_data(in_store_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic rw, input logic ld, input logic st,
                    input logic [2:0] f3, input logic [4:0] rd,
                    input logic [31:0] addr, input logic [31:0] sd);
    in_valid = v; in_reg_write = rw; in_is_load = ld; in_is_store = st;
    in_funct3 = f3; in_rd = rd; in_addr = addr; in_store_data = sd;
  endtask

  initial begin
    rst = 1'b1;
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 32'h0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_err", err, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data", write_data, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // ALU op, then back-to-back ALU ops, then ALU to x0
    op(1, 1, 0, 0, 3'b000, 5'd5, 32'h1234_5678, 32'h0);
    tick();
    chk("alu_reg_write", reg_write, 1);
    chk("alu_write_addr", write_addr, 5);
    chk("alu_write_data", write_data, 32'h1234_5678);
    chk("alu_in_ready", in_ready, 1);
    op(1, 1, 0, 0, 3'b000, 5'd6, 32'hAAAA_0001, 32'h0);
    tick();
    chk("b2b1_reg_write", reg_write, 1);
    chk("b2b1_write_data", write_data, 32'hAAAA_0001);
    op(1, 1, 0, 0, 3'b000, 5'd0, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("alu_x0_reg_write", reg_write, 0);
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    tick();
    chk("alu_idle_reg_write", reg_write, 0);

    // LB at 0x103, two stall cycles, stray rvalid in REQ ignored
    op(1, 1, 1, 0, 3'b000, 5'd3, 32'h0000_0103, 32'h0);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("lb_dm_req", dm_req, 1);
    chk("lb_dm_addr", dm_addr, 32'h0000_0100);
    chk("lb_dm_we", dm_we, 0);
    chk("lb_in_ready_req", in_ready, 0);
    dm_rvalid = 1; dm_rdata = 32'h1111_1111;
    tick();
    chk("lb_stall1_req", dm_req, 1);
    chk("lb_stall1_reg_write", reg_write, 0);
    dm_rvalid = 0;
    tick();
    chk("lb_stall2_req", dm_req, 1);
    chk("lb_stall2_in_ready", in_ready, 0);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    chk("lb_wait_req", dm_req, 0);
    chk("lb_wait_in_ready", in_ready, 0);
    tick();
    chk("lb_wait2_in_ready", in_ready, 0);
    dm_rvalid = 1; dm_rdata = 32'h80FF_FFFF;
    tick();
    dm_rvalid = 0;
    chk("lb_reg_write", reg_write, 1);
    chk("lb_write_addr", write_addr, 3);
    chk("lb_write_data", write_data, 32'hFFFF_FF80);
    chk("lb_in_ready_done", in_ready, 1);
    tick();
    chk("lb_reg_write_once", reg_write, 0);

    // SH at 0x202
    op(1, 0, 0, 1, 3'b001, 5'd0, 32'h0000_0202, 32'h0000_ABCD);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("sh_dm_req", dm_req, 1);
    chk("sh_dm_we", dm_we, 4'b1100);
    chk("sh_dm_addr", dm_addr, 32'h0000_0200);
    chk("sh_dm_wdata", dm_wdata, 32'hABCD_ABCD);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    chk("sh_done_in_ready", in_ready, 1);
    chk("sh_done_req", dm_req, 0);
    chk("sh_reg_write", reg_write, 0);

    // SB at 0x001
    op(1, 0, 0, 1, 3'b000, 5'd0, 32'h0000_0001, 32'h1234_565A);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("sb_dm_we", dm_we, 4'b0010);
    chk("sb_dm_wdata", dm_wdata, 32'h5A5A_5A5A);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    chk("sb_done_in_ready", in_ready, 1);

    // Misaligned LW, then next op accepted immediately
    op(1, 1, 1, 0, 3'b010, 5'd7, 32'h0000_0101, 32'h0);
    tick();
    chk("lw_mis_err", err, 1);
    chk("lw_mis_req", dm_req, 0);
    chk("lw_mis_reg_write", reg_write, 0);
    chk("lw_mis_in_ready", in_ready, 1);
    op(1, 1, 0, 0, 3'b000, 5'd9, 32'h0000_CAFE, 32'h0);
    tick();
    chk("after_err_err", err, 0);
    chk("after_err_reg_write", reg_write, 1);
    chk("after_err_write_data", write_data, 32'h0000_CAFE);
    op(1, 0, 0, 1, 3'b011, 5'd0, 32'h0000_0000, 32'h0);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("st_badf3_err", err, 1);
    chk("st_badf3_req", dm_req, 0);
    tick();
    chk("err_one_cycle", err, 0);

    // LHU to x0 at 0x2, simultaneous gnt+rvalid in REQ is grant only
    op(1, 1, 1, 0, 3'b101, 5'd0, 32'h0000_0002, 32'h0);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    chk("lhu0_dm_req", dm_req, 1);
    chk("lhu0_dm_addr", dm_addr, 32'h0);
    dm_gnt = 1; dm_rvalid = 1; dm_rdata = 32'h8001_0000;
    tick();
    dm_gnt = 0; dm_rvalid = 0;
    chk("lhu0_wait_in_ready", in_ready, 0);
    chk("lhu0_wait_reg_write", reg_write, 0);
    dm_rvalid = 1;
    tick();
    dm_rvalid = 0;
    chk("lhu0_done_in_ready", in_ready, 1);
    chk("lhu0_reg_write", reg_write, 0);

    // LH rd=4 at 0x2 sign-extends the upper half
    op(1, 1, 1, 0, 3'b001, 5'd4, 32'h0000_0002, 32'h0);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    dm_gnt = 1;
    tick();
    dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'h8001_0000;
    tick();
    dm_rvalid = 0;
    chk("lh_reg_write", reg_write, 1);
    chk("lh_write_data", write_data, 32'hFFFF_8001);

    // Reset in WAIT, late rvalid afterwards
    op(1, 1, 1, 0, 3'b010, 5'd8, 32'h0000_0010, 32'h0);
    tick();
    op(0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    chk("rstw_in_wait", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_dm_req", dm_req, 0);
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_dm_addr", dm_addr, 0);
    chk("rstw_reg_write", reg_write, 0);
    tick();
    rst = 1'b0;
    dm_rvalid = 1; dm_rdata = 32'h5555_5555;
    tick();
    dm_rvalid = 0;
    chk("rstw_late_reg_write", reg_write, 0);
    chk("rstw_late_in_ready", in_ready, 1);
    tick();
    chk("rstw_late2_reg_write", reg_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL provide these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream (EX/MEM) op valid.
- in_ready  out  1  block can accept an op.
- in_reg_write  in  1  op writes rd.
- in_is_load  in  1  op is a load.
- in_is_store  in  1  op is a store.
- in_funct3  in  3  RV32I load/store width code.
- in_rd  in  5  destination register.
- in_addr  in  32  effective address, or ALU result for non-memory ops.
- in_store_data  in  32  rs2 value for stores.
- dm_req  out  1  data-memory request.
- dm_we  out  4  byte write strobes; 0000 = read.
- dm_addr  out  32  word-aligned address.
- dm_wdata  out  32  lane-aligned store data.
- dm_gnt  in  1  request accepted this cycle.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  32  read word.
- reg_write  out  1  register-file write enable.
- write_addr  out  5  register-file write address.
- write_data  out  32  register-file write data.
- err  out  1  one-cycle misaligned/illegal-access pulse.

Function
REQ-002 The FSM SHALL have states IDLE, REQ, WAIT; in_ready SHALL equal (state==IDLE).
REQ-003 An op is accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-004 An accepted non-memory op with in_reg_write=1 and in_rd!=0 SHALL drive reg_write=1 for exactly the next cycle, with write_addr=in_rd and write_data=in_addr; state SHALL stay IDLE, so throughput is 1 op/cycle.
REQ-005 reg_write SHALL be registered, SHALL pulse for exactly one cycle per completed write, and SHALL never assert when the destination is x0.
REQ-006 Loads use funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-007 Any other funct3 code, a halfword access with addr[0]=1, or a word access with addr[1:0]!=00 SHALL:
- issue no dm_req;
- pulse err for the next cycle;
- produce no reg_write;
- leave the FSM in IDLE.
REQ-008 An accepted legal load/store SHALL move the FSM to REQ. While in REQ:
- dm_req=1;
- dm_addr={addr[31:2],2'b00};
- dm_addr, dm_we and dm_wdata SHALL be registered at acceptance and held stable until the grant.
REQ-009 Store strobes and data:
- SB: dm_we=0001<<addr[1:0], store byte replicated into all four lanes.
- SH: dm_we=0011<<{addr[1],1'b0}, store halfword replicated into both halves.
- SW: dm_we=1111.
- Loads: dm_we=0000.
REQ-010 In REQ with dm_gnt=1, a store SHALL return to IDLE and a load SHALL go to WAIT; with dm_gnt=0 the FSM SHALL stay in REQ indefinitely.
REQ-011 In WAIT with dm_rvalid=1, the FSM SHALL:
- select the byte or halfword at addr[1:0];
- sign-extend (LB/LH) or zero-extend (LBU/LHU);
- register the result into write_data and assert reg_write for the next cycle (rd!=0);
- return to IDLE on the same edge.
Load-to-writeback latency is therefore 1 cycle after rvalid.
REQ-012 dm_rvalid outside WAIT, and dm_gnt outside REQ, SHALL be ignored.
REQ-013 dm_rvalid and dm_gnt asserted in the same cycle in REQ SHALL be treated as a grant only.
REQ-014 A load to x0 SHALL still complete the memory transaction but SHALL NOT assert reg_write.

Reset
REQ-015 While rst=1, the block SHALL immediately (asynchronously) force:
- FSM=IDLE;
- in_ready=1;
- reg_write=0, err=0, dm_req=0;
- dm_we=0000, dm_addr=0, dm_wdata=0, write_addr=0, write_data=0.
REQ-016 Reset during REQ or WAIT SHALL abandon the transaction; a late dm_rvalid after reset release SHALL produce no reg_write.

Verification
REQ-017 ALU op in_addr=0x1234_5678, rd=5, accepted at cycle N -> reg_write=1, write_addr=5, write_data=0x1234_5678 in cycle N+1 only.
REQ-018 LB at addr 0x103, gnt after 2 stall cycles, rdata=0x80FF_FFFF -> write_data=0xFFFF_FF80 one cycle after rvalid; in_ready=0 throughout.
REQ-019 SH at 0x202 with store data 0x0000_ABCD -> dm_we=1100, dm_addr=0x200, dm_wdata=0xABCD_ABCD; no reg_write.
REQ-020 LW at 0x101 -> err pulses one cycle, dm_req stays 0, reg_write stays 0, next op accepted the cycle after.
REQ-021 LHU rd=0 at 0x2 with rdata=0x8001_0000 -> full transaction completes, reg_write stays 0.
REQ-022 rst asserted in WAIT, then rvalid after release -> dm_req=0 immediately, no reg_write, in_ready=1.
